step_peek_ctrl: RTL and testbench

STEP_PEEK_CTRL -- requirements
Module: step_peek_ctrl

---
 rtl/step_peek_pkg.sv | 21 ++
 rtl/step_peek_ctrl_hex7seg.sv | 32 +++
 rtl/step_peek_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_step_peek_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_peek_pkg.sv
// rtl/step_peek_pkg.sv - shared types and constants for the step/peek front panel
package step_peek_pkg;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 3;
  localparam int SEG_W  = 8;
  localparam int TMR_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    PEEK_REQ,
    PEEK_SHOW
  } state_t;

  // Active-low segments, bit 7 is DP (kept dark)
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
  localparam logic [SEG_W-1:0] SEG_P     = 8'h8C;
  localparam logic [SEG_W-1:0] SEG_E     = 8'h86;

endpackage

// File: rtl/step_peek_ctrl_hex7seg.sv
// rtl/step_peek_ctrl_hex7seg.sv - nibble to active-low seven-segment pattern, DP off
module hex7seg
  import step_peek_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/step_peek_ctrl.sv
// rtl/step_peek_ctrl.sv - step/peek key controller with register peek display
// STEP_COUNT_EN: LED_B shows a wrapping step counter instead of mirroring Data_in.
module step_peek_ctrl
  import step_peek_pkg::*;
#(
  parameter int PEEK_HOLD   = 150_000_000,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RSTb,
  input  logic              CLK_clean,
  input  logic              PK_clean,
  input  logic [DATA_W-1:0] Data_in,
  input  logic [DATA_W-1:0] peek_data,
  input  logic              peek_ack,
  output logic              step,
  output logic              peek_req,
  output logic [ADDR_W-1:0] peek_addr,
  output logic [DATA_W-1:0] LED_B,
  output logic [SEG_W-1:0]  HEX0,
  output logic [SEG_W-1:0]  HEX1,
  output logic [SEG_W-1:0]  HEX2,
  output logic [SEG_W-1:0]  HEX3,
  output logic [SEG_W-1:0]  HEX4,
  output logic [SEG_W-1:0]  HEX5
);

  localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(PEEK_HOLD - 1);

  state_t              state, state_d;
  logic [TMR_W-1:0]    tmr, tmr_d;
  logic                step_pend, step_pend_d;
  logic                peek_pend, peek_pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   val, val_d;
  logic                err, err_d;
  logic                step_key_q, peek_key_q;
  logic                step_ev, peek_ev;

  assign step_ev   = step_key_q & ~CLK_clean;
  assign peek_ev   = peek_key_q & ~PK_clean;
  assign step      = (state == STEP);
  assign peek_req  = (state == PEEK_REQ);
  assign peek_addr = addr_q;

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state      <= IDLE;
      tmr        <= '0;
      step_pend  <= 1'b0;
      peek_pend  <= 1'b0;
      addr_q     <= '0;
      val        <= '0;
      err        <= 1'b0;
      step_key_q <= 1'b1;
      peek_key_q <= 1'b1;
    end else begin
      state      <= state_d;
      tmr        <= tmr_d;
      step_pend  <= step_pend_d;
      peek_pend  <= peek_pend_d;
      addr_q     <= addr_d;
      val        <= val_d;
      err        <= err_d;
      step_key_q <= CLK_clean;
      peek_key_q <= PK_clean;
    end
  end

  // One timer serves both the ack wait and the display hold; it restarts on each entry.
  always_comb begin
    state_d     = state;
    tmr_d       = tmr;
    step_pend_d = step_pend;
    peek_pend_d = peek_pend;
    addr_d      = addr_q;
    val_d       = val;
    err_d       = err;
    case (state)
      IDLE: begin
        if (step_ev || step_pend) begin
          state_d     = STEP;
          step_pend_d = 1'b0;
          if (peek_ev) peek_pend_d = 1'b1;
        end else if (peek_ev || peek_pend) begin
          state_d     = PEEK_REQ;
          addr_d      = Data_in[ADDR_W-1:0];
          peek_pend_d = 1'b0;
          tmr_d       = '0;
        end
      end
      STEP: begin
        state_d = IDLE;
        if (step_ev) step_pend_d = 1'b1;
        if (peek_ev) peek_pend_d = 1'b1;
      end
      PEEK_REQ: begin
        if (step_ev) step_pend_d = 1'b1;
        if (peek_ack) begin
          val_d   = peek_data;
          err_d   = 1'b0;
          state_d = PEEK_SHOW;
          tmr_d   = '0;
        end else if (tmr == ACK_LAST) begin
          val_d   = '1;
          err_d   = 1'b1;
          state_d = PEEK_SHOW;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      PEEK_SHOW: begin
        if (step_ev || step_pend) begin
          state_d     = STEP;
          step_pend_d = 1'b0;
          if (peek_ev) peek_pend_d = 1'b1;
        end else if (peek_ev) begin
          state_d = PEEK_REQ;
          addr_d  = Data_in[ADDR_W-1:0];
          tmr_d   = '0;
        end else if (tmr == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [DATA_W-1:0] disp;
  logic [SEG_W-1:0]  seg0, seg1, seg2, seg4;

  assign disp = (state == PEEK_SHOW) ? val : Data_in;

  hex7seg u_dig0 (.nibble(disp[3:0]),          .seg(seg0));
  hex7seg u_dig1 (.nibble(disp[7:4]),          .seg(seg1));
  hex7seg u_dig2 (.nibble({2'b00, disp[9:8]}), .seg(seg2));
  hex7seg u_dig4 (.nibble({1'b0, addr_q}),     .seg(seg4));

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      HEX0 <= SEG_BLANK;
      HEX1 <= SEG_BLANK;
      HEX2 <= SEG_BLANK;
      HEX3 <= SEG_BLANK;
      HEX4 <= SEG_BLANK;
      HEX5 <= SEG_BLANK;
    end else begin
      case (state)
        IDLE, STEP: begin
          HEX0 <= seg0;
          HEX1 <= seg1;
          HEX2 <= seg2;
          HEX3 <= SEG_BLANK;
          HEX4 <= SEG_BLANK;
          HEX5 <= SEG_BLANK;
        end
        PEEK_SHOW: begin
          HEX0 <= seg0;
          HEX1 <= seg1;
          HEX2 <= seg2;
          HEX3 <= SEG_BLANK;
          HEX4 <= seg4;
          HEX5 <= err ? SEG_E : SEG_P;
        end
        default: ;
      endcase
    end
  end

`ifdef STEP_COUNT_EN
  logic [DATA_W-1:0] step_cnt;

  always_ff @(posedge CLK) begin
    if (!RSTb) step_cnt <= '0;
    else if (state == STEP) step_cnt <= step_cnt + 1'b1;
  end

  assign LED_B = step_cnt;
`else
  logic [DATA_W-1:0] led_q;

  always_ff @(posedge CLK) begin
    if (!RSTb) led_q <= '0;
    else led_q <= Data_in;
  end

  assign LED_B = led_q;
`endif

endmodule

// File: tb/tb_step_peek_ctrl.sv
// tb/tb_step_peek_ctrl.sv - self-checking bench for step_peek_ctrl against a behavioural model
module tb_step_peek_ctrl;

  localparam int HOLD = 20;
  localparam int TMO  = 16;
  localparam int M_IDLE = 0, M_PULSE = 1, M_WAIT = 2, M_SHOW = 3;

  logic       CLK = 1'b0;
  logic       RSTb = 1'b0;
  logic       CLK_clean = 1'b1;
  logic       PK_clean = 1'b1;
  logic [9:0] Data_in = '0;
  logic [9:0] peek_data = '0;
  logic       peek_ack = 1'b0;
  logic       step, peek_req;
  logic [2:0] peek_addr;
  logic [9:0] LED_B;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  always #10 CLK = ~CLK;

  step_peek_ctrl #(.PEEK_HOLD(HOLD), .ACK_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RSTb(RSTb), .CLK_clean(CLK_clean), .PK_clean(PK_clean),
    .Data_in(Data_in), .peek_data(peek_data), .peek_ack(peek_ack),
    .step(step), .peek_req(peek_req), .peek_addr(peek_addr), .LED_B(LED_B),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Reference model: mode plus countdown of cycles remaining in the wait/show phases
  int         m_mode = M_IDLE;
  int         m_left = 0;
  bit         m_sp = 1'b0, m_pp = 1'b0, m_err = 1'b0;
  bit         m_ks = 1'b1, m_kp = 1'b1;
  logic [2:0] m_addr = '0;
  logic [9:0] m_val = '0, m_led = '0;
  logic [7:0] m_hex [6];
  logic       m_sev, m_pev;

  assign m_sev = m_ks && !CLK_clean;
  assign m_pev = m_kp && !PK_clean;

  always @(posedge CLK) begin
    if (!RSTb) begin
      m_mode <= M_IDLE; m_left <= 0; m_sp <= 1'b0; m_pp <= 1'b0; m_err <= 1'b0;
      m_addr <= '0; m_val <= '0; m_led <= '0; m_ks <= 1'b1; m_kp <= 1'b1;
      m_hex[0] <= 8'hFF; m_hex[1] <= 8'hFF; m_hex[2] <= 8'hFF;
      m_hex[3] <= 8'hFF; m_hex[4] <= 8'hFF; m_hex[5] <= 8'hFF;
    end else begin
      m_ks <= CLK_clean;
      m_kp <= PK_clean;
      if (m_mode == M_IDLE || m_mode == M_PULSE) begin
        m_hex[0] <= seg(Data_in[3:0]); m_hex[1] <= seg(Data_in[7:4]);
        m_hex[2] <= seg({2'b00, Data_in[9:8]});
        m_hex[3] <= 8'hFF; m_hex[4] <= 8'hFF; m_hex[5] <= 8'hFF;
      end else if (m_mode == M_SHOW) begin
        m_hex[0] <= seg(m_val[3:0]); m_hex[1] <= seg(m_val[7:4]);
        m_hex[2] <= seg({2'b00, m_val[9:8]});
        m_hex[3] <= 8'hFF; m_hex[4] <= seg({1'b0, m_addr});
        m_hex[5] <= m_err ? 8'h86 : 8'h8C;
      end
`ifdef STEP_COUNT_EN
      if (m_mode == M_PULSE) m_led <= m_led + 10'd1;
`else
      m_led <= Data_in;
`endif
      case (m_mode)
        M_IDLE:
          if (m_sev || m_sp) begin
            m_mode <= M_PULSE; m_sp <= 1'b0;
            if (m_pev) m_pp <= 1'b1;
          end else if (m_pev || m_pp) begin
            m_mode <= M_WAIT; m_addr <= Data_in[2:0]; m_pp <= 1'b0; m_left <= TMO;
          end
        M_PULSE: begin
          m_mode <= M_IDLE;
          if (m_sev) m_sp <= 1'b1;
          if (m_pev) m_pp <= 1'b1;
        end
        M_WAIT: begin
          if (m_sev) m_sp <= 1'b1;
          if (peek_ack) begin
            m_val <= peek_data; m_err <= 1'b0; m_mode <= M_SHOW; m_left <= HOLD;
          end else if (m_left == 1) begin
            m_val <= 10'h3FF; m_err <= 1'b1; m_mode <= M_SHOW; m_left <= HOLD;
          end else begin
            m_left <= m_left - 1;
          end
        end
        default:
          if (m_sev || m_sp) begin
            m_mode <= M_PULSE; m_sp <= 1'b0;
            if (m_pev) m_pp <= 1'b1;
          end else if (m_pev) begin
            m_mode <= M_WAIT; m_addr <= Data_in[2:0]; m_left <= TMO;
          end else if (m_left == 1) begin
            m_mode <= M_IDLE;
          end else begin
            m_left <= m_left - 1;
          end
      endcase
    end
  end

  bit cmp_on = 1'b0;

  initial forever begin
    @(negedge CLK);
    if (cmp_on) begin
      chk("step", step, m_mode == M_PULSE);
      chk("peek_req", peek_req, m_mode == M_WAIT);
      chk("peek_addr", peek_addr, m_addr);
      chk("led_b", LED_B, m_led);
      chk("hex0", HEX0, m_hex[0]);
      chk("hex1", HEX1, m_hex[1]);
      chk("hex2", HEX2, m_hex[2]);
      chk("hex3", HEX3, m_hex[3]);
      chk("hex4", HEX4, m_hex[4]);
      chk("hex5", HEX5, m_hex[5]);
    end
  end

  // Register-file responder: ack after resp_lat cycles of peek_req; noise acks in random mode
  bit         resp_en = 1'b0, rnd_mode = 1'b0, force_ack = 1'b0;
  int         resp_lat = 0;
  logic [9:0] resp_data = '0;

  initial begin
    int req_cyc;
    req_cyc = 0;
    forever begin
      @(negedge CLK);
      if (force_ack) begin
        peek_ack = 1'b1;
        peek_data = 10'h155;
      end else if (peek_req && resp_en) begin
        peek_ack = (req_cyc == resp_lat);
        peek_data = rnd_mode ? 10'($urandom_range(0, 1023)) : resp_data;
        req_cyc++;
      end else begin
        peek_ack = rnd_mode && ($urandom_range(0, 15) == 0);
        peek_data = 10'($urandom_range(0, 1023));
        req_cyc = 0;
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int pulses, n, hi, shown, found;

    tick(2);
    chk("rst_step", step, 0);
    chk("rst_peek_req", peek_req, 0);
    chk("rst_peek_addr", peek_addr, 0);
    chk("rst_led", LED_B, 0);
    chk("rst_hex", {HEX0, HEX1, HEX2, HEX3} & {HEX4, HEX5, 16'hFFFF}, 32'hFFFF_FFFF);
    chk("rst_hex_or", {HEX0, HEX1, HEX2, HEX3} | {HEX4, HEX5, 16'h0000}, 32'hFFFF_FFFF);
    cmp_on = 1'b1;
    RSTb = 1'b1;
    tick(2);

`ifdef STEP_COUNT_EN
    repeat (1025) begin
      CLK_clean = 1'b0; tick(2);
      CLK_clean = 1'b1; tick(2);
    end
    tick(2);
    chk("led_after_1025_steps", LED_B, 10'd1);
`endif

    // Held step key: one event only
    pulses = 0;
    CLK_clean = 1'b0;
    repeat (100) begin tick(); if (step) pulses++; end
    CLK_clean = 1'b1;
    repeat (4) begin tick(); if (step) pulses++; end
    chk("held_key_pulses", pulses, 1);

    // Peek with ack on the fourth request cycle
    Data_in = 10'h005; resp_en = 1'b1; resp_lat = 3; resp_data = 10'h2A7;
    PK_clean = 1'b0; tick(); PK_clean = 1'b1;
    n = 0; hi = 1;
    while (n < 40 && peek_req) begin tick(); n++; if (peek_req) hi++; end
    chk("ack_req_dropped", peek_req, 0);
    chk("ack_req_cycles", hi, 4);
    tick();
    chk("show_hex2", HEX2, 8'hA4);
    chk("show_hex1", HEX1, 8'h88);
    chk("show_hex0", HEX0, 8'hF8);
    chk("show_hex3", HEX3, 8'hFF);
    chk("show_hex4", HEX4, 8'h92);
    chk("show_hex5", HEX5, 8'h8C);
    shown = 1;
    repeat (HOLD + 5) begin tick(); if (HEX5 == 8'h8C) shown++; end
    chk("show_hold_cycles", shown, HOLD);
    chk("idle_hex5", HEX5, 8'hFF);

    // Peek with no ack: timeout frame
    Data_in = 10'h003; resp_en = 1'b0;
    PK_clean = 1'b0; tick(); PK_clean = 1'b1;
    n = 0; hi = peek_req ? 1 : 0;
    while (n < 40 && peek_req) begin tick(); n++; if (peek_req) hi++; end
    chk("tmo_req_cycles", hi, TMO);
    tick();
    chk("tmo_hex2", HEX2, 8'hB0);
    chk("tmo_hex1", HEX1, 8'h8E);
    chk("tmo_hex0", HEX0, 8'h8E);
    chk("tmo_hex4", HEX4, 8'hB0);
    chk("tmo_hex5", HEX5, 8'h86);
    tick(HOLD + 5);

    // Simultaneous step and peek: step first, peek served afterwards
    resp_en = 1'b1; resp_lat = 1;
    CLK_clean = 1'b0; PK_clean = 1'b0; tick();
    CLK_clean = 1'b1; PK_clean = 1'b1;
    chk("both_step_first", step, 1);
    chk("both_no_req_yet", peek_req, 0);
    found = 0;
    repeat (3) begin tick(); if (peek_req) found = 1; end
    chk("both_peek_follows", found, 1);
    tick(HOLD + 10);

    // Reset while a request is outstanding, then a late ack
    resp_en = 1'b0;
    PK_clean = 1'b0; tick(); PK_clean = 1'b1;
    chk("req_before_reset", peek_req, 1);
    RSTb = 1'b0; tick();
    chk("req_after_reset", peek_req, 0);
    chk("reset_hex_lo", {HEX0, HEX1, HEX2}, 24'hFFFFFF);
    chk("reset_hex_hi", {HEX3, HEX4, HEX5}, 24'hFFFFFF);
    RSTb = 1'b1; force_ack = 1'b1; tick(); force_ack = 1'b0; tick(2);
    chk("late_ack_ignored_req", peek_req, 0);
    chk("late_ack_ignored_hex5", HEX5, 8'hFF);

    // Random traffic against the model
    rnd_mode = 1'b1;
    repeat (3000) begin
      tick();
      if ($urandom_range(0, 5) == 0) CLK_clean = ~CLK_clean;
      if ($urandom_range(0, 5) == 0) PK_clean = ~PK_clean;
      if ($urandom_range(0, 9) == 0) Data_in = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 19) == 0) begin
        resp_en = 1'($urandom_range(0, 1));
        resp_lat = $urandom_range(0, 20);
      end
      RSTb = ($urandom_range(0, 499) != 0);
    end
    RSTb = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
